// File: rtl/divider_nbit_seq_pkg.sv
// Shared divider definitions: FSM state encoding, also used by the FP divider.
package divider_nbit_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/adder_nbit_cin.sv
// N-bit adder with carry-in; IMPL_TYPE 0 is the native adder, anything else a ripple chain.
module adder_nbit_cin #(
  parameter int WIDTH     = 8,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  if (IMPL_TYPE == 0) begin : g_behav
    assign sum = a + b + {{(WIDTH-1){1'b0}}, cin};
  end else begin : g_ripple
    always_comb begin : ripple
      logic c;
      c   = cin;
      sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
        sum[i] = a[i] ^ b[i] ^ c;
        c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
  end

endmodule

// File: rtl/divider_nbit_seq.sv
// Restoring unsigned divider, 2W/W -> W quotient + W remainder, one quotient bit per cycle.
// Result after W+2 cycles (2 on divide-by-zero/overflow); busy blocks in_ready, result holds until out_ready.
module divider_nbit_seq
  import divider_nbit_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] N,
  input  logic [WIDTH-1:0]   D,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Q,
  output logic [WIDTH-1:0]   R,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = WIDTH + 2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] qsh_q, qsh_d;
  logic [WIDTH-1:0] dreg_q, dreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [AW-1:0]    add_a, add_b, add_sum;
  logic             nonneg;
  logic             unused_sum_bit;

  // One subtractor serves both the overflow probe (rem - d) and each RUN step ({rem,msb} - d).
  always_comb begin
    add_a = {2'b00, rem_q};
    if (state_q == ST_RUN) begin
      add_a = {1'b0, rem_q, qsh_q[WIDTH-1]};
    end
    add_b = ~{2'b00, dreg_q};
  end

  adder_nbit_cin #(
    .WIDTH     (AW),
    .IMPL_TYPE (IMPL_TYPE)
  ) u_sub (
    .a   (add_a),
    .b   (add_b),
    .cin (1'b1),
    .sum (add_sum)
  );

  assign nonneg         = ~add_sum[AW-1];
  assign unused_sum_bit = add_sum[WIDTH];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    qsh_d   = qsh_q;
    dreg_d  = dreg_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          rem_d   = N[2*WIDTH-1:WIDTH];
          qsh_d   = N[WIDTH-1:0];
          dreg_d  = D;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Error results reuse the datapath regs: qsh becomes all ones, rem the captured low dividend.
        if (dreg_q == '0) begin
          dbz_d   = 1'b1;
          rem_d   = qsh_q;
          qsh_d   = '1;
          state_d = ST_DONE;
        end else if (nonneg) begin
          ovf_d   = 1'b1;
          rem_d   = qsh_q;
          qsh_d   = '1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = CW'(WIDTH);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rem_d = nonneg ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
        qsh_d = {qsh_q[WIDTH-2:0], nonneg};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      qsh_q   <= '0;
      dreg_q  <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      qsh_q   <= qsh_d;
      dreg_q  <= dreg_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign Q           = out_valid ? qsh_q : '0;
  assign R           = out_valid ? rem_q : '0;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
